freq_meter: RTL and testbench

Gated frequency counter clocked from the 50 MHz board oscillator. It measures an external square wave, such as a divided clock returned from another block or the FPGA pins, by counting its rising edges over a fixed gate window. At the end of each window it publishes the count as frequency in edges per gate, so with the default 1 s gate the result is in Hz. It is the measurement end of the clock-divider chain: divider output in, numeric frequency out for display or self-check logic.

---
 rtl/freq_meter.sv | 65 ++++++
 tb/tb_freq_meter.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/freq_meter.sv
// freq_meter: counts rising edges of sig_in over a fixed gate window and publishes edges per gate
module freq_meter #(
    parameter int GATE_CYCLES = 50_000_000,
    parameter int CNT_W       = 32
) (
    input  logic             clk_50mhz,
    input  logic             rst,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] freq_out,
    output logic             freq_valid,
    output logic             overflow
);
    localparam int GW = $clog2(GATE_CYCLES);
    localparam logic [GW-1:0] LAST = GW'(GATE_CYCLES - 1);

    logic s1, s2, s3, run, sat;
    logic [GW-1:0] gate_cnt;
    logic [CNT_W-1:0] edge_cnt, sum_sat;
    logic [CNT_W:0] sum_w;
    logic rise, act, close, carry;

    assign rise    = s2 & ~s3;
    assign act     = en & run;
    assign close   = act && gate_cnt == LAST;
    assign sum_w   = {1'b0, edge_cnt} + {{CNT_W{1'b0}}, rise};
    assign carry   = sum_w[CNT_W];
    assign sum_sat = carry ? '1 : sum_w[CNT_W-1:0];

    // two-flop synchronizer plus edge-detect delay flop
    always_ff @(posedge clk_50mhz or negedge rst) begin
        if (!rst) {s1, s2, s3} <= '0;
        else      {s1, s2, s3} <= {sig_in, s1, s2};
    end

    // gate and edge counters; the first enabled sample only arms the gate so gate_cnt is 0 after it
    always_ff @(posedge clk_50mhz or negedge rst) begin
        if (!rst) begin
            run      <= 1'b0;
            gate_cnt <= '0;
            edge_cnt <= '0;
            sat      <= 1'b0;
        end else begin
            run      <= en;
            gate_cnt <= (!act || close) ? '0 : gate_cnt + GW'(1);
            edge_cnt <= (!act || close) ? '0 : sum_sat;
            sat      <= act && !close && (sat || carry);
        end
    end

    // publish the closing gate's count, including an edge landing on the closing cycle
    always_ff @(posedge clk_50mhz or negedge rst) begin
        if (!rst) begin
            freq_out   <= '0;
            freq_valid <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            freq_valid <= close;
            if (close) begin
                freq_out <= sum_sat;
                overflow <= sat | carry;
            end
        end
    end
endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: directed table-driven checks of freq_meter with 100-cycle gates
module tb_freq_meter;
    typedef struct {
        int period;
        int f;
        int o;
        int f4;
        int o4;
    } vec_t;

    logic clk = 1'b0, rst = 1'b0, en = 1'b0;
    logic manual = 1'b0, man_sig = 1'b0, gen_sig = 1'b0;
    logic sig_in;
    logic [31:0] freq_out;
    logic [3:0] freq4;
    logic freq_valid, overflow, fv4, ov4;
    int cyc = 0, ph = 0, period = 10, checks = 0, errors = 0;

    assign sig_in = manual ? man_sig : gen_sig;

    freq_meter #(.GATE_CYCLES(100), .CNT_W(32)) dut (
        .clk_50mhz(clk), .rst(rst), .en(en), .sig_in(sig_in),
        .freq_out(freq_out), .freq_valid(freq_valid), .overflow(overflow)
    );

    freq_meter #(.GATE_CYCLES(100), .CNT_W(4)) dut4 (
        .clk_50mhz(clk), .rst(rst), .en(en), .sig_in(sig_in),
        .freq_out(freq4), .freq_valid(fv4), .overflow(ov4)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        gen_sig = period != 0 && (ph % period) < period / 2;
        ph++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish, required finish before 500000");
        $fatal(1);
    end

    task automatic chk(input string n, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", n, act, exp);
        end
    endtask

    task automatic wait_valid(output int at);
        at = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (freq_valid) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            checks++;
            errors++;
            $display("FAIL valid_timeout got no freq_valid in 300 cycles expected one");
        end
    endtask

    initial begin
        vec_t vt[7];
        int at, last, c, nv, a;
        vt = '{'{10, 10, 0, 10, 0}, '{0, 0, 0, 0, 0}, '{4, 25, 0, 15, 1}, '{10, 10, 0, 10, 0},
               '{5, 20, 0, 15, 1}, '{20, 5, 0, 5, 0}, '{10, 10, 0, 10, 0}};
        repeat (3) @(negedge clk);
        chk("rst_freq", freq_out, 0);
        chk("rst_valid", freq_valid, 0);
        chk("rst_ovf", overflow, 0);
        rst = 1'b1;
        en = 1'b1;
        c = cyc;
        wait_valid(at);
        chk("first_valid_lat", at - c, 101);
        last = at;
        wait_valid(at);
        chk("gate_period", at - last, 100);
        chk("steady_freq", freq_out, 10);
        chk("steady_ovf", overflow, 0);
        repeat (40) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("async_rst_freq", freq_out, 0);
        chk("async_rst_valid", freq_valid, 0);
        chk("async_rst_ovf", overflow, 0);
        chk("async_rst_freq4", freq4, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        c = cyc;
        wait_valid(at);
        chk("post_rst_lat", at - c, 101);
        foreach (vt[i]) begin
            period = vt[i].period;
            repeat (2) wait_valid(at);
            last = at;
            wait_valid(at);
            chk($sformatf("vec%0d_period", i), at - last, 100);
            chk($sformatf("vec%0d_freq", i), freq_out, vt[i].f);
            chk($sformatf("vec%0d_ovf", i), overflow, vt[i].o);
            chk($sformatf("vec%0d_freq4", i), freq4, vt[i].f4);
            chk($sformatf("vec%0d_ovf4", i), ov4, vt[i].o4);
            chk($sformatf("vec%0d_valid4", i), fv4, 1);
        end
        while (cyc < at + 50) @(negedge clk);
        en = 1'b0;
        nv = 0;
        repeat (20) begin
            @(negedge clk);
            if (freq_valid || fv4) nv++;
        end
        chk("drop_no_valid", nv, 0);
        chk("drop_hold_freq", freq_out, 10);
        chk("drop_hold_freq4", freq4, 10);
        en = 1'b1;
        c = cyc;
        wait_valid(at);
        chk("reen_lat", at - c, 101);
        chk("reen_freq", freq_out, 10);
        manual = 1'b1;
        man_sig = 1'b0;
        wait_valid(at);
        wait_valid(at);
        chk("idle_manual_freq", freq_out, 0);
        a = at;
        while (cyc < a + 97) @(negedge clk);
        man_sig = 1'b1;
        wait_valid(at);
        chk("close_edge_lat", at - a, 100);
        chk("close_edge_cnt", freq_out, 1);
        man_sig = 1'b0;
        wait_valid(at);
        chk("after_close_cnt", freq_out, 0);
        a = at;
        while (cyc < a + 98) @(negedge clk);
        man_sig = 1'b1;
        wait_valid(at);
        chk("late_edge_gate0", freq_out, 0);
        man_sig = 1'b0;
        wait_valid(at);
        chk("late_edge_gate1", freq_out, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
